// File: rtl/mining_job_ctrl.sv
// rtl/mining_job_ctrl.sv - job/result front end for fpgaminer_top; optional JOBCTRL_STATS_EN adds stat_jobs/stat_found
module mining_job_ctrl #(
   parameter int LOOP_LOG2 = 5,
   parameter int DRAIN     = 2 * (1 << LOOP_LOG2) + 4
) (
   input  logic         hash_clk,
   input  logic         reset,
   input  logic         job_valid,
   output logic         job_ready,
   input  logic [255:0] job_midstate,
   input  logic [95:0]  job_data,
   input  logic [31:0]  job_nonce_min,
   input  logic [31:0]  job_nonce_max,
   input  logic         abort,
   output logic [255:0] miner_midstate,
   output logic [95:0]  miner_work_data,
   output logic [31:0]  miner_nonce_min,
   output logic [31:0]  miner_nonce_max,
   output logic         miner_reset,
   input  logic [31:0]  miner_golden_nonce,
   input  logic         miner_new_golden_nonce,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [31:0]  res_nonce,
   output logic [1:0]   res_status,
`ifdef JOBCTRL_STATS_EN
   output logic [31:0]  stat_jobs,
   output logic [31:0]  stat_found,
`endif
   output logic         busy
);

   localparam logic [1:0]  ST_REJECTED  = 2'b00;
   localparam logic [1:0]  ST_FOUND     = 2'b01;
   localparam logic [1:0]  ST_EXHAUSTED = 2'b10;
   localparam logic [1:0]  ST_ABORTED   = 2'b11;
   localparam logic [31:0] DRAIN_LAST   = 32'(DRAIN - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_MINE, S_DRAIN, S_REPORT
   } state_t;

   state_t state;

   logic                 slot_full;
   logic [255:0]         slot_midstate;
   logic [95:0]          slot_data;
   logic [31:0]          slot_min;
   logic [31:0]          slot_max;

   logic [LOOP_LOG2-1:0] per_cnt;
   logic [32:0]          done_cnt;
   logic [32:0]          span;
   logic [31:0]          drain_cnt;
   logic                 gold_q;

   logic pop;
   logic gold_hit;
   logic abort_hit;
   logic res_hs;

   assign job_ready = ~slot_full;
   assign pop       = (state == S_IDLE) && slot_full;
   assign res_hs    = res_valid && res_ready;
   assign gold_hit  = miner_new_golden_nonce && !gold_q &&
                      (state == S_MINE || state == S_DRAIN);
   assign abort_hit = abort && (state == S_LOAD || state == S_START ||
                                state == S_MINE || state == S_DRAIN);

   // Single pending-job slot: filled on handshake, emptied when IDLE pops it.
   always_ff @(posedge hash_clk) begin
      if (reset) begin
         slot_full     <= 1'b0;
         slot_midstate <= '0;
         slot_data     <= '0;
         slot_min      <= '0;
         slot_max      <= '0;
      end else if (pop) begin
         slot_full <= 1'b0;
      end else if (job_valid && !slot_full) begin
         slot_full     <= 1'b1;
         slot_midstate <= job_midstate;
         slot_data     <= job_data;
         slot_min      <= job_nonce_min;
         slot_max      <= job_nonce_max;
      end
   end

   // Registered copy of the golden strobe for rising-edge detection.
   always_ff @(posedge hash_clk) begin
      if (reset) gold_q <= 1'b0;
      else       gold_q <= miner_new_golden_nonce;
   end

   // Job FSM: abort beats golden beats exhaustion; all outputs registered.
   always_ff @(posedge hash_clk) begin
      if (reset) begin
         state           <= S_IDLE;
         miner_midstate  <= '0;
         miner_work_data <= '0;
         miner_nonce_min <= '0;
         miner_nonce_max <= '0;
         miner_reset     <= 1'b0;
         res_valid       <= 1'b0;
         res_nonce       <= '0;
         res_status      <= ST_REJECTED;
         busy            <= 1'b0;
         per_cnt         <= '0;
         done_cnt        <= '0;
         span            <= '0;
         drain_cnt       <= '0;
      end else begin
         miner_reset <= 1'b0;
         if (abort_hit) begin
            state      <= S_REPORT;
            res_valid  <= 1'b1;
            res_status <= ST_ABORTED;
            res_nonce  <= '0;
         end else if (gold_hit) begin
            state      <= S_REPORT;
            res_valid  <= 1'b1;
            res_status <= ST_FOUND;
            res_nonce  <= miner_golden_nonce;
         end else begin
            case (state)
               S_IDLE: begin
                  if (slot_full) begin
                     busy <= 1'b1;
                     if (slot_min > slot_max) begin
                        state      <= S_REPORT;
                        res_valid  <= 1'b1;
                        res_status <= ST_REJECTED;
                        res_nonce  <= '0;
                     end else begin
                        miner_midstate  <= slot_midstate;
                        miner_work_data <= slot_data;
                        miner_nonce_min <= slot_min;
                        miner_nonce_max <= slot_max;
                        state           <= S_LOAD;
                     end
                  end
               end
               // Give the miner one cycle to see the new work before its reset.
               S_LOAD: state <= S_START;
               S_START: begin
                  miner_reset <= 1'b1;
                  per_cnt     <= '0;
                  done_cnt    <= '0;
                  span        <= {1'b0, miner_nonce_max} - {1'b0, miner_nonce_min} + 33'd1;
                  state       <= S_MINE;
               end
               S_MINE: begin
                  per_cnt <= per_cnt + LOOP_LOG2'(1);
                  if (&per_cnt) done_cnt <= done_cnt + 33'd1;
                  if (done_cnt == span) begin
                     state     <= S_DRAIN;
                     drain_cnt <= '0;
                  end
               end
               // Let the pipeline flush results for the last nonces.
               S_DRAIN: begin
                  if (drain_cnt == DRAIN_LAST) begin
                     state      <= S_REPORT;
                     res_valid  <= 1'b1;
                     res_status <= ST_EXHAUSTED;
                     res_nonce  <= miner_nonce_max;
                  end else begin
                     drain_cnt <= drain_cnt + 32'd1;
                  end
               end
               S_REPORT: begin
                  if (res_ready) begin
                     res_valid <= 1'b0;
                     busy      <= 1'b0;
                     state     <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

`ifdef JOBCTRL_STATS_EN
   // Result counters, advanced on each accepted result.
   always_ff @(posedge hash_clk) begin
      if (reset) begin
         stat_jobs  <= '0;
         stat_found <= '0;
      end else if (res_hs) begin
         stat_jobs <= stat_jobs + 32'd1;
         if (res_status == ST_FOUND) stat_found <= stat_found + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mining_job_ctrl.sv
// tb/tb_mining_job_ctrl.sv - directed scoreboard bench for mining_job_ctrl
module tb_mining_job_ctrl;

   logic         hash_clk = 1'b0;
   logic         reset = 1'b1;
   logic         job_valid = 1'b0;
   logic         job_ready;
   logic [255:0] job_midstate = '0;
   logic [95:0]  job_data = '0;
   logic [31:0]  job_nonce_min = '0;
   logic [31:0]  job_nonce_max = '0;
   logic         abort = 1'b0;
   logic [255:0] miner_midstate;
   logic [95:0]  miner_work_data;
   logic [31:0]  miner_nonce_min;
   logic [31:0]  miner_nonce_max;
   logic         miner_reset;
   logic [31:0]  miner_golden_nonce = '0;
   logic         miner_new_golden_nonce = 1'b0;
   logic         res_valid;
   logic         res_ready = 1'b0;
   logic [31:0]  res_nonce;
   logic [1:0]   res_status;
   logic         busy;
`ifdef JOBCTRL_STATS_EN
   logic [31:0]  stat_jobs;
   logic [31:0]  stat_found;
`endif

   mining_job_ctrl dut (
      .hash_clk               (hash_clk),
      .reset                  (reset),
      .job_valid              (job_valid),
      .job_ready              (job_ready),
      .job_midstate           (job_midstate),
      .job_data               (job_data),
      .job_nonce_min          (job_nonce_min),
      .job_nonce_max          (job_nonce_max),
      .abort                  (abort),
      .miner_midstate         (miner_midstate),
      .miner_work_data        (miner_work_data),
      .miner_nonce_min        (miner_nonce_min),
      .miner_nonce_max        (miner_nonce_max),
      .miner_reset            (miner_reset),
      .miner_golden_nonce     (miner_golden_nonce),
      .miner_new_golden_nonce (miner_new_golden_nonce),
      .res_valid              (res_valid),
      .res_ready              (res_ready),
      .res_nonce              (res_nonce),
      .res_status             (res_status),
`ifdef JOBCTRL_STATS_EN
      .stat_jobs              (stat_jobs),
      .stat_found             (stat_found),
`endif
      .busy                   (busy)
   );

   always #5 hash_clk = ~hash_clk;

   int cyc = 0;
   always @(posedge hash_clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]  st;
      logic [31:0] nonce;
   } exp_t;
   exp_t exp_q[$];

   int errors = 0;
   int checks = 0;

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge hash_clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [1:0] st, input logic [31:0] nonce);
      exp_t e;
      e.st = st;
      e.nonce = nonce;
      exp_q.push_back(e);
   endtask

   task automatic submit(input logic [31:0] mn, input logic [31:0] mx,
                         input logic [255:0] ms, input logic [95:0] wd, output int acc);
      int w = 0;
      while (!job_ready && w < 500) begin
         step();
         w++;
      end
      check("submit_ready", job_ready, 1);
      job_midstate  = ms;
      job_data      = wd;
      job_nonce_min = mn;
      job_nonce_max = mx;
      job_valid     = 1'b1;
      step();
      acc = cyc;
      job_valid = 1'b0;
   endtask

   task automatic wait_mreset(output int at);
      int w = 0;
      while (!miner_reset && w < 400) begin
         step();
         w++;
      end
      check("wait_miner_reset", miner_reset, 1);
      at = cyc;
   endtask

   task automatic get_result(input int hold, output int rv_at, output int hs_at);
      int w = 0;
      exp_t e;
      logic [31:0] n0;
      logic [1:0] s0;
      bit stable = 1;
      while (!res_valid && w < 1000) begin
         step();
         w++;
      end
      check("wait_res_valid", res_valid, 1);
      rv_at = cyc;
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("res_status", res_status, e.st);
         check("res_nonce", res_nonce, e.nonce);
      end
      n0 = res_nonce;
      s0 = res_status;
      repeat (hold) begin
         step();
         if (res_valid !== 1'b1 || res_nonce !== n0 || res_status !== s0) stable = 0;
      end
      if (hold > 0) check("hold_stable", stable, 1);
      res_ready = 1'b1;
      step();
      hs_at = cyc;
      res_ready = 1'b0;
      check("res_valid_drop", res_valid, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, acc_b, mr, rv, hs;
      bit saw_mr, saw_rv;

      // reset values
      reset = 1'b1;
      step(3);
      check("rst_job_ready", job_ready, 1);
      check("rst_res_valid", res_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_miner_reset", miner_reset, 0);
      check("rst_midstate", miner_midstate[63:0], 0);
      check("rst_nonce_max", miner_nonce_max, 0);
      check("rst_res_status", res_status, 0);
      check("rst_res_nonce", res_nonce, 0);
      reset = 1'b0;
      step(2);

      // rejected: min > max, no miner start pulse
      push_exp(2'b00, 32'h0);
      submit(32'd5, 32'd4, 256'h1, 96'h1, acc);
      saw_mr = 0;
      for (int w = 0; w < 20 && !res_valid; w++) begin
         step();
         if (miner_reset) saw_mr = 1;
      end
      check("rej_no_miner_reset", saw_mr, 0);
      get_result(0, rv, hs);
`ifdef JOBCTRL_STATS_EN
      check("rej_stat_jobs", stat_jobs, 1);
      check("rej_stat_found", stat_found, 0);
`endif
      step(2);

      // exhaustion over 4 nonces
      push_exp(2'b10, 32'h103);
      submit(32'h100, 32'h103, {8{32'hDEAD_BEEF}}, 96'h0123_4567_89AB_CDEF_0011_2233, acc);
      wait_mreset(mr);
      check("start_latency", mr - acc, 3);
      check("ex_midstate", miner_midstate[255:192], 64'hDEAD_BEEF_DEAD_BEEF);
      check("ex_work_data", miner_work_data[63:0], 64'h89AB_CDEF_0011_2233);
      check("ex_nonce_min", miner_nonce_min, 32'h100);
      step();
      check("miner_reset_one_cycle", miner_reset, 0);
      get_result(0, rv, hs);
      check("exhaust_latency", rv - mr, 197);
      step(2);

      // golden nonce found mid-sweep, later pulse ignored
      push_exp(2'b01, 32'h0000_ABCD);
      submit(32'h0, 32'hFFFF, 256'h2, 96'h2, acc);
      wait_mreset(mr);
      step(50);
      miner_golden_nonce = 32'h0000_ABCD;
      miner_new_golden_nonce = 1'b1;
      step();
      check("found_latency", res_valid, 1);
      miner_new_golden_nonce = 1'b0;
      get_result(0, rv, hs);
      miner_golden_nonce = 32'h0000_5555;
      miner_new_golden_nonce = 1'b1;
      step();
      miner_new_golden_nonce = 1'b0;
      step(3);
      check("late_golden_ignored", res_valid, 0);
      check("late_golden_busy", busy, 0);

      // abort and golden in the same cycle: abort wins
      push_exp(2'b11, 32'h0);
      submit(32'h0, 32'hFFFF, 256'h3, 96'h3, acc);
      wait_mreset(mr);
      step(10);
      abort = 1'b1;
      miner_golden_nonce = 32'h1234;
      miner_new_golden_nonce = 1'b1;
      step();
      abort = 1'b0;
      miner_new_golden_nonce = 1'b0;
      get_result(0, rv, hs);
      step();
      check("abort_busy_clear", busy, 0);

      // queued second job with result backpressure
      push_exp(2'b10, 32'h10);
      push_exp(2'b10, 32'h20);
      submit(32'h10, 32'h10, 256'h4, 96'h4, acc);
      submit(32'h20, 32'h20, 256'h5, 96'h5, acc_b);
      check("queue_second_accept", acc_b - acc, 2);
      check("queue_job_ready_low", job_ready, 0);
      check("queue_busy", busy, 1);
      get_result(10, rv, hs);
      wait_mreset(mr);
      check("next_start_after_hs", mr - hs, 3);
      check("queue_b_loaded", miner_nonce_min, 32'h20);
      get_result(0, rv, hs);
      step(2);

      // full 2^32 sweep, then reset while mining with a job pending
      submit(32'h0, 32'hFFFF_FFFF, 256'h6, 96'h6, acc);
      wait_mreset(mr);
      step();
      check("full_span", dut.span, 33'h1_0000_0000);
      step(99);
      check("done_cnt_100", dut.done_cnt, 3);
      submit(32'h1, 32'h2, 256'h7, 96'h7, acc);
      check("pending_held", job_ready, 0);
      reset = 1'b1;
      step();
      check("mid_rst_job_ready", job_ready, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_res_valid", res_valid, 0);
      check("mid_rst_nonce_max", miner_nonce_max, 0);
      check("mid_rst_midstate", miner_midstate[31:0], 0);
      check("mid_rst_res_status", res_status, 0);
      reset = 1'b0;
      saw_mr = 0;
      saw_rv = 0;
      for (int w = 0; w < 300; w++) begin
         step();
         if (miner_reset) saw_mr = 1;
         if (res_valid) saw_rv = 1;
      end
      check("post_rst_no_start", saw_mr, 0);
      check("post_rst_no_result", saw_rv, 0);
      check("post_rst_idle", busy, 0);
      check("sb_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
